sipo_frame_rx: RTL

Serial frame receiver that sits directly downstream of the SISO shift register and consumes its `data_out` bitstream, one bit per clock. Detects a start bit, deserialises a WIDTH-bit MSB-first payload, checks even parity and the stop bit, and presents the recovered word in parallel with a one-cycle valid strobe. Also keeps a wrapping count of good frames for bring-up and debug.

---
 rtl/sipo_frame_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
// Serial frame receiver fed by the SISO stage's bitstream, one bit per clock.
// Frame: start(1), WIDTH data bits MSB first, even parity bit, stop(0).
// Good frames are presented in parallel with a one-cycle valid strobe, and
// a wrapping 8-bit count of good frames is kept for bring-up.
//
// Ports:
//   clk_i         clock, all sampling on the rising edge
//   rst_i         asynchronous active-high reset
//   data_in_i     serial line, idle level 0
//   data_out_o    last good payload, MSB = first data bit received
//   valid_o       one-cycle pulse, data_out_o just loaded with a good frame
//   parity_err_o  one-cycle pulse, frame ended with bad parity
//   frame_err_o   one-cycle pulse, frame ended with stop bit = 1
//   busy_o        high whenever the receiver is not idle
//   frame_cnt_o   good-frame count, wraps 255 -> 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | hunting for a start bit (1) on the line
// S_DATA   | shifting in WIDTH payload bits, MSB first
// S_PARITY | capturing the parity bit
// S_STOP   | sampling the stop bit and judging the frame

module sipo_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_in_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             valid_o,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             busy_o,
    output logic [7:0]       frame_cnt_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic             par_bad;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic, including the deserialiser
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_in_i) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                shift_d   = {shift_q[WIDTH-2:0], data_in_i};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                par_d   = data_in_i;
                state_d = S_STOP;
            end
            S_STOP: begin
                // The stop bit is consumed here; a 1 is never taken as a start.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: status pulses are decided while in S_STOP, registered
    // on the stop edge, and therefore last exactly one cycle.
    always_comb begin
        par_bad     = (^shift_q) ^ par_q;
        valid_d     = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        busy_o      = (state_q != S_IDLE);
        if (state_q == S_STOP) begin
            perr_d = par_bad;
            ferr_d = data_in_i;
            if (!par_bad && !data_in_i) begin
                valid_d     = 1'b1;
                data_d      = shift_q;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    assign data_out_o   = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
